// File: rtl/pr_edge_issue_ctrl_pkg.sv
// Shared widths, credit depth and FSM encoding for the PageRank edge issue controller.
package pr_edge_issue_ctrl_pkg;

   localparam int EDGE_PIPE_NUM             = 4;
   localparam int VERTEX_BRAM_DWIDTH        = 32;
   localparam int VERTEX_BRAM_DEGREE_DWIDTH = 32;
   localparam int TOT_EDGE_MASK_WIDTH       = 4;
   localparam int TOT_ACC_ID_WIDTH          = 8;
   localparam int CREDIT_NUM                = 16;
   localparam int CNT_WIDTH                 = 32;

   localparam int SRC_P_W  = VERTEX_BRAM_DWIDTH * EDGE_PIPE_NUM;
   localparam int DEGREE_W = VERTEX_BRAM_DEGREE_DWIDTH * EDGE_PIPE_NUM;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } issue_state_e;

   // Counter width able to hold the value n itself (credits start full).
   function automatic int count_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/pr_credit_counter.sv
// Up/down credit counter: starts full, inc returns a credit, dec consumes one.
module pr_credit_counter #(
   parameter int MAX = 16,
   parameter int W   = $clog2(MAX + 1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc_i,
   input  logic         dec_i,
   output logic [W-1:0] count_o,
   output logic         zero_o,
   output logic         full_o,
   output logic         ovf_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;
   logic         inc_eff;
   logic         dec_eff;

   assign zero_o  = (count_q == '0);
   assign full_o  = (count_q == W'(MAX));
   // A return while already full has no matching entry downstream: drop it and flag.
   assign ovf_o   = inc_i && full_o;
   assign inc_eff = inc_i && !full_o;
   assign dec_eff = dec_i && !zero_o;
   assign count_o = count_q;

   always_comb begin
      count_d = count_q;
      if (inc_eff && !dec_eff) begin
         count_d = count_q + W'(1);
      end else if (dec_eff && !inc_eff) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= W'(MAX);
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pr_edge_issue_ctrl.sv
// Issue controller: meters edge batches into edge_process under downstream FIFO credits
// and reports iteration completion once every issued batch has retired.
module pr_edge_issue_ctrl
   import pr_edge_issue_ctrl_pkg::*;
#(
   parameter int CREDITS = CREDIT_NUM
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [CNT_WIDTH-1:0]           edge_num,
   input  logic                           s_valid,
   output logic                           s_ready,
   input  logic [SRC_P_W-1:0]             s_src_p,
   input  logic [DEGREE_W-1:0]            s_degree,
   input  logic [TOT_EDGE_MASK_WIDTH-1:0] s_mask,
   input  logic [TOT_ACC_ID_WIDTH-1:0]    s_acc_id,
   output logic [SRC_P_W-1:0]             ep_src_p,
   output logic [DEGREE_W-1:0]            ep_degree,
   output logic [TOT_EDGE_MASK_WIDTH-1:0] ep_src_p_mask,
   output logic [TOT_ACC_ID_WIDTH-1:0]    ep_tot_acc_id,
   output logic                           ep_src_p_valid,
   input  logic                           ep_ret_valid,
   input  logic                           credit_return,
   output logic                           busy,
   output logic                           done,
   output logic [CNT_WIDTH-1:0]           issued_cnt,
   output logic                           err,
   output issue_state_e                   dbg_state_o
);

   localparam int CW = count_width(CREDITS);

   // Upstream handshake: a batch moves when s_valid && s_ready at a rising edge;
   // while s_ready is low the fetch stage must hold s_valid and the batch stable.

   issue_state_e            state_q;
   logic [CNT_WIDTH-1:0]    edge_num_q;
   logic [CNT_WIDTH-1:0]    issued_q;
   logic [CNT_WIDTH-1:0]    retired_q;
   logic                    done_q;
   logic                    err_q;

   logic [CW-1:0]           credits;
   logic                    credit_zero;
   logic                    credit_full;
   logic                    credit_ovf;

   logic                    issue_ok;
   logic                    fire;
   logic                    last_fire;
   logic                    ret_in_iter;
   logic                    ret_overrun;
   logic                    ret_count;
   logic                    last_ret;
   logic                    ret_stray;

   pr_credit_counter #(
      .MAX (CREDITS),
      .W   (CW)
   ) u_credit (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc_i   (credit_return),
      .dec_i   (fire),
      .count_o (credits),
      .zero_o  (credit_zero),
      .full_o  (credit_full),
      .ovf_o   (credit_ovf)
   );

   assign issue_ok    = (state_q == ST_ISSUE) && !credit_zero && (issued_q < edge_num_q);
   assign fire        = s_valid && issue_ok;
   assign last_fire   = fire && ((issued_q + CNT_WIDTH'(1)) == edge_num_q);

   assign ret_in_iter = ep_ret_valid && ((state_q == ST_ISSUE) || (state_q == ST_DRAIN));
   assign ret_overrun = ret_in_iter && (retired_q == edge_num_q);
   assign ret_count   = ret_in_iter && !ret_overrun;
   assign last_ret    = ret_count && ((retired_q + CNT_WIDTH'(1)) == edge_num_q);
   assign ret_stray   = ep_ret_valid && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         edge_num_q <= '0;
         issued_q   <= '0;
         retired_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (fire) begin
            issued_q <= issued_q + CNT_WIDTH'(1);
         end
         if (ret_count) begin
            retired_q <= retired_q + CNT_WIDTH'(1);
         end
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  edge_num_q <= edge_num;
                  issued_q   <= '0;
                  retired_q  <= '0;
                  if (edge_num == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               if (last_fire) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Done is raised in the cycle right after the final retire is seen.
               if (last_ret || (retired_q == edge_num_q)) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Idle cycles present zero data and an all-ones accumulator id to edge_process.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ep_src_p       <= '0;
         ep_degree      <= '0;
         ep_src_p_mask  <= '0;
         ep_tot_acc_id  <= '1;
         ep_src_p_valid <= 1'b0;
      end else if (fire) begin
         ep_src_p       <= s_src_p;
         ep_degree      <= s_degree;
         ep_src_p_mask  <= s_mask;
         ep_tot_acc_id  <= s_acc_id;
         ep_src_p_valid <= 1'b1;
      end else begin
         ep_src_p       <= '0;
         ep_degree      <= '0;
         ep_src_p_mask  <= '0;
         ep_tot_acc_id  <= '1;
         ep_src_p_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (credit_ovf || ret_overrun || ret_stray) begin
         err_q <= 1'b1;
      end
   end

   assign s_ready     = issue_ok;
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign issued_cnt  = issued_q;
   assign err         = err_q;
   assign dbg_state_o = state_q;

   logic unused_ok;
   assign unused_ok = credit_full ^ (|credits);

endmodule

// File: tb/tb_pr_edge_issue_ctrl.sv
// Randomized bench for pr_edge_issue_ctrl with a transaction-level reference model.
module tb_pr_edge_issue_ctrl;
  import pr_edge_issue_ctrl_pkg::*;

  localparam int CRED  = 4;
  localparam int DELAY = 3;

  typedef struct packed {
    logic [SRC_P_W-1:0]             src;
    logic [DEGREE_W-1:0]            deg;
    logic [TOT_EDGE_MASK_WIDTH-1:0] mask;
    logic [TOT_ACC_ID_WIDTH-1:0]    acc;
  } batch_t;

  logic                           clk;
  logic                           rst_n;
  logic                           start;
  logic [CNT_WIDTH-1:0]           edge_num;
  logic                           s_valid;
  logic                           s_ready;
  logic [SRC_P_W-1:0]             s_src_p;
  logic [DEGREE_W-1:0]            s_degree;
  logic [TOT_EDGE_MASK_WIDTH-1:0] s_mask;
  logic [TOT_ACC_ID_WIDTH-1:0]    s_acc_id;
  logic [SRC_P_W-1:0]             ep_src_p;
  logic [DEGREE_W-1:0]            ep_degree;
  logic [TOT_EDGE_MASK_WIDTH-1:0] ep_src_p_mask;
  logic [TOT_ACC_ID_WIDTH-1:0]    ep_tot_acc_id;
  logic                           ep_src_p_valid;
  logic                           ep_ret_valid;
  logic                           credit_return;
  logic                           busy;
  logic                           done;
  logic [CNT_WIDTH-1:0]           issued_cnt;
  logic                           err;
  issue_state_e                   dbg_state;

  pr_edge_issue_ctrl #(.CREDITS(CRED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .edge_num(edge_num),
    .s_valid(s_valid), .s_ready(s_ready), .s_src_p(s_src_p), .s_degree(s_degree),
    .s_mask(s_mask), .s_acc_id(s_acc_id),
    .ep_src_p(ep_src_p), .ep_degree(ep_degree), .ep_src_p_mask(ep_src_p_mask),
    .ep_tot_acc_id(ep_tot_acc_id), .ep_src_p_valid(ep_src_p_valid),
    .ep_ret_valid(ep_ret_valid), .credit_return(credit_return),
    .busy(busy), .done(done), .issued_cnt(issued_cnt), .err(err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: iteration bookkeeping in plain counters
  batch_t exp_q[$];
  int     ret_q[$];
  int     m_credits, m_issued, m_retired, m_n, occ, cyc;
  bit     m_active, m_done_now, m_err;

  // driver state
  bit          cur_valid;
  batch_t      cur;
  int          vprob, cprob;
  bit          start_req, force_cr, force_ret;
  logic [31:0] start_n;

  task automatic model_reset();
    m_credits = CRED; m_issued = 0; m_retired = 0; m_n = 0; occ = 0;
    m_active = 0; m_done_now = 0; m_err = 0; cur_valid = 0;
    exp_q.delete(); ret_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; credit_return = 1'b0; ep_ret_valid = 1'b0;
    model_reset();
    #1;
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_ep_valid", ep_src_p_valid, 1'b0);
    chk("rst_ep_acc_id", ep_tot_acc_id, 8'hFF);
    chk("rst_ep_src_p", ep_src_p, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_issued", issued_cnt, 32'd0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // one clock: check outputs, drive inputs, then advance the model
  task automatic tick();
    bit exp_ready, fire, ret_now, cr_now, idle_old, done_next;
    @(negedge clk);
    exp_ready = m_active && (m_credits > 0) && (m_issued < m_n);
    chk("s_ready", s_ready, exp_ready);
    chk("busy", busy, m_active || m_done_now);
    chk("done", done, m_done_now);
    chk("issued_cnt", issued_cnt, m_issued);
    chk("err", err, m_err);
    start     = start_req;
    edge_num  = start_n;
    start_req = 0;
    if (!cur_valid && ($urandom_range(99) < vprob)) begin
      cur_valid = 1;
      cur.src   = {$urandom, $urandom, $urandom, $urandom};
      cur.deg   = {$urandom, $urandom, $urandom, $urandom};
      cur.mask  = 4'($urandom);
      cur.acc   = 8'($urandom);
    end
    s_valid  = cur_valid;
    s_src_p  = cur.src;
    s_degree = cur.deg;
    s_mask   = cur.mask;
    s_acc_id = cur.acc;
    cr_now   = force_cr || ((occ > 0) && ($urandom_range(99) < cprob));
    force_cr = 0;
    credit_return = cr_now;
    ret_now  = force_ret || ((ret_q.size() > 0) && (ret_q[0] == cyc));
    force_ret = 0;
    ep_ret_valid = ret_now;
    @(posedge clk);
    idle_old  = !m_active && !m_done_now;
    done_next = 0;
    fire      = cur_valid && exp_ready;
    if ((ret_q.size() > 0) && (ret_q[0] == cyc)) void'(ret_q.pop_front());
    if (cr_now) begin
      if (m_credits == CRED) m_err = 1;
      else begin
        m_credits++;
        if (occ > 0) occ--;
      end
    end
    if (fire) begin
      exp_q.push_back(cur);
      ret_q.push_back(cyc + 1 + DELAY);
      m_issued++; m_credits--; occ++;
      cur_valid = 0;
    end
    if (ret_now) begin
      if (m_active) begin
        m_retired++;
        if (m_retired == m_n) begin
          m_active  = 0;
          done_next = 1;
        end
      end else m_err = 1;
    end
    if (start && idle_old) begin
      m_issued = 0; m_retired = 0; m_n = start_n;
      if (start_n == 0) done_next = 1;
      else m_active = 1;
    end
    m_done_now = done_next;
    cyc++;
  endtask

  task automatic run_cycles(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic finish_iter();
    int budget = 2000;
    while ((m_active || m_done_now) && (budget > 0)) begin
      tick();
      budget--;
    end
    if (budget == 0) chk("iter_timeout", 1'b1, 1'b0);
  endtask

  task automatic run_iter(input int n, input int vp, input int cp);
    start_req = 1; start_n = n; vprob = vp; cprob = cp;
    tick();
    finish_iter();
    tick();
  endtask

  task automatic drain_credits();
    int budget = 200;
    cprob = 100;
    while ((occ > 0) && (budget > 0)) begin
      tick();
      budget--;
    end
    if (budget == 0) chk("drain_timeout", 1'b1, 1'b0);
  endtask

  // scoreboard monitor: pops one expected batch per issued batch
  initial begin
    batch_t got, want;
    forever begin
      @(negedge clk);
      got = {ep_src_p, ep_degree, ep_src_p_mask, ep_tot_acc_id};
      if (ep_src_p_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("ep_unexpected", 1'b1, 1'b0);
        else begin
          want = exp_q.pop_front();
          chk("ep_batch", got, want);
        end
      end else begin
        want = '0;
        want.acc = '1;
        chk("ep_idle", got, want);
      end
    end
  end

  initial begin
    rst_n = 1'b1; start = 0; edge_num = '0; s_valid = 0; s_src_p = '0; s_degree = '0;
    s_mask = '0; s_acc_id = '0; ep_ret_valid = 0; credit_return = 0;
    cyc = 0; vprob = 0; cprob = 0; start_req = 0; start_n = 0; force_cr = 0; force_ret = 0;
    cur = '0;
    model_reset();
    apply_reset();
    run_cycles(2);

    run_iter(3, 100, 40);            // back-to-back issue
    drain_credits();
    run_iter(0, 100, 0);             // empty iteration
    for (int i = 0; i < 8; i++) begin
      run_iter($urandom_range(12, 1), $urandom_range(100, 30), $urandom_range(90, 20));
    end
    drain_credits();

    // credit stall then a single return
    start_req = 1; start_n = 6; vprob = 100; cprob = 0;
    run_cycles(12);
    force_cr = 1;
    run_cycles(6);
    cprob = 60;
    finish_iter();
    drain_credits();

    // reset with batches in flight
    start_req = 1; start_n = 8; vprob = 100; cprob = 0;
    run_cycles(3);
    apply_reset();
    run_cycles(8);

    // protocol errors in idle, then credits still full afterwards
    force_cr = 1;
    run_cycles(3);
    force_ret = 1;
    run_cycles(3);
    start_req = 1; start_n = 6; vprob = 100; cprob = 0;
    run_cycles(10);
    cprob = 70;
    finish_iter();
    drain_credits();
    run_cycles(4);

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
